// File: rtl/bcd_digit_source_4x7seg.sv
// Four-digit BCD up/down counter stepped by a clock prescaler, with registered
// 7-segment outputs (bit6 = A .. bit0 = G) and optional leading-zero blanking.
module bcd_digit_source_4x7seg #(
  parameter int PRESCALE        = 1000,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit BLANK_LZ        = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        up_down,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count_bcd,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic        tick,
  output logic        wrap
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [6:0]    ZERO_PAT   = SEG_ACTIVE_HIGH ? 7'b1111110 : 7'b0000001;
  localparam logic [6:0]    BLANK_PAT  = SEG_ACTIVE_HIGH ? 7'b0000000 : 7'b1111111;
  localparam logic [6:0]    LEAD_RST   = BLANK_LZ ? BLANK_PAT : ZERO_PAT;

  logic [PW-1:0] presc;
  logic [15:0]   step_val;
  logic          step_wrap;
  logic [15:0]   load_clean;
  logic          step_due;
  logic [6:0]    seg_next [4];

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1111110;
      4'd1:    enc = 7'b0110000;
      4'd2:    enc = 7'b1101101;
      4'd3:    enc = 7'b1111001;
      4'd4:    enc = 7'b0110011;
      4'd5:    enc = 7'b1011011;
      4'd6:    enc = 7'b1011111;
      4'd7:    enc = 7'b1110000;
      4'd8:    enc = 7'b1111111;
      4'd9:    enc = 7'b1111011;
      default: enc = 7'b0000000;
    endcase
  endfunction

  // Ripple a +1/-1 through the digits; a carry out of digit 3 is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    step_val = count_bcd;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = count_bcd[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; carry = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; carry = 1'b0; end
        end
      end
      step_val[4*i +: 4] = d;
    end
    step_wrap = carry;
  end

  always_comb begin
    load_clean = 16'h0000;
    for (int i = 0; i < 4; i++)
      load_clean[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
  end

  assign step_due = enable && (presc == PRESC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_bcd <= 16'h0000;
      presc     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (clear) begin
      count_bcd <= 16'h0000;
      presc     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      count_bcd <= load_clean;
      presc     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (step_due) begin
      count_bcd <= step_val;
      presc     <= '0;
      tick      <= 1'b1;
      wrap      <= step_wrap;
    end else begin
      if (enable) presc <= presc + 1'b1;
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // A leading digit blanks only when it and every digit above it are zero.
  always_comb begin
    logic [3:0] blank;
    logic [6:0] raw;
    blank[3] = BLANK_LZ && (count_bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (count_bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (count_bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      raw         = blank[n] ? 7'b0000000 : enc(count_bcd[4*n +: 4]);
      seg_next[n] = SEG_ACTIVE_HIGH ? raw : ~raw;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg0 <= ZERO_PAT;
      seg1 <= LEAD_RST;
      seg2 <= LEAD_RST;
      seg3 <= LEAD_RST;
    end else begin
      seg0 <= seg_next[0];
      seg1 <= seg_next[1];
      seg2 <= seg_next[2];
      seg3 <= seg_next[3];
    end
  end

endmodule

// File: tb/tb_bcd_digit_source_4x7seg.sv
// Bench for bcd_digit_source_4x7seg: two instances (plain and inverted/blanked)
// share one stimulus stream and are checked every cycle against an integer model.
module tb_bcd_digit_source_4x7seg;

  localparam int PS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [15:0] cnt_a, cnt_b;
  logic [6:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic        tick_a, wrap_a, tick_b, wrap_b;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  bcd_digit_source_4x7seg #(.PRESCALE(PS), .SEG_ACTIVE_HIGH(1'b1), .BLANK_LZ(1'b0)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count_bcd(cnt_a),
    .seg0(a0), .seg1(a1), .seg2(a2), .seg3(a3), .tick(tick_a), .wrap(wrap_a));

  bcd_digit_source_4x7seg #(.PRESCALE(PS), .SEG_ACTIVE_HIGH(1'b0), .BLANK_LZ(1'b1)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count_bcd(cnt_b),
    .seg0(b0), .seg1(b1), .seg2(b2), .seg3(b3), .tick(tick_b), .wrap(wrap_b));

  // ---------------- behavioural model ----------------
  int n_val = 0;      // count as a plain integer 0..9999
  int presc = 0;
  int seg_val = 0;    // count value the segment outputs currently display
  bit exp_tick = 1'b0;
  bit exp_wrap = 1'b0;
  logic [6:0] seg_tab [10];

  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
  end

  function automatic int load_to_int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 0;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int n, input bit act_high, input bit blank_lz);
    int p = 1;
    logic [6:0] raw;
    for (int i = 0; i < n; i++) p *= 10;
    raw = (blank_lz && n > 0 && v < p) ? 7'b0000000 : seg_tab[(v / p) % 10];
    return act_high ? raw : ~raw;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n_val <= 0; presc <= 0; seg_val <= 0; exp_tick <= 1'b0; exp_wrap <= 1'b0;
    end else begin
      seg_val <= n_val;
      if (clear) begin
        n_val <= 0; presc <= 0; exp_tick <= 1'b0; exp_wrap <= 1'b0;
      end else if (load) begin
        n_val <= load_to_int(load_value); presc <= 0; exp_tick <= 1'b0; exp_wrap <= 1'b0;
      end else if (enable && presc == PS - 1) begin
        presc    <= 0;
        n_val    <= up_down ? (n_val + 1) % 10000 : (n_val + 9999) % 10000;
        exp_tick <= 1'b1;
        exp_wrap <= up_down ? (n_val == 9999) : (n_val == 0);
      end else begin
        if (enable) presc <= presc + 1;
        exp_tick <= 1'b0;
        exp_wrap <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("count_a", cnt_a, int_to_bcd(n_val));
      check("count_b", cnt_b, int_to_bcd(n_val));
      check("tick_a", 16'(tick_a), 16'(exp_tick));
      check("wrap_a", 16'(wrap_a), 16'(exp_wrap));
      check("tick_b", 16'(tick_b), 16'(exp_tick));
      check("wrap_b", 16'(wrap_b), 16'(exp_wrap));
      check("a_seg0", 16'(a0), 16'(exp_seg(seg_val, 0, 1'b1, 1'b0)));
      check("a_seg1", 16'(a1), 16'(exp_seg(seg_val, 1, 1'b1, 1'b0)));
      check("a_seg2", 16'(a2), 16'(exp_seg(seg_val, 2, 1'b1, 1'b0)));
      check("a_seg3", 16'(a3), 16'(exp_seg(seg_val, 3, 1'b1, 1'b0)));
      check("b_seg0", 16'(b0), 16'(exp_seg(seg_val, 0, 1'b0, 1'b1)));
      check("b_seg1", 16'(b1), 16'(exp_seg(seg_val, 1, 1'b0, 1'b1)));
      check("b_seg2", 16'(b2), 16'(exp_seg(seg_val, 2, 1'b0, 1'b1)));
      check("b_seg3", 16'(b3), 16'(exp_seg(seg_val, 3, 1'b0, 1'b1)));
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after a falling edge: outputs are stable, inputs may change.
  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clock);
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    cyc();
    load = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    checking = 1'b1;
    cyc(2);
    check("rst_count", cnt_a, 16'h0000);
    check("rst_a_seg0", 16'(a0), 16'(7'b1111110));
    check("rst_b_seg3", 16'(b3), 16'(7'b1111111));
    check("rst_b_seg0", 16'(b0), 16'(7'b0000001));

    // counting up from reset
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    cyc(3);
    check("pre_tick", 16'(tick_a), 16'h0000);
    cyc();
    check("first_step", cnt_a, 16'h0001);
    check("first_tick", 16'(tick_a), 16'h0001);
    cyc();
    check("seg0_one", 16'(a0), 16'(7'b0110000));

    // up wrap
    do_load(16'h9998);
    cyc(4);
    check("up_9999", cnt_a, 16'h9999);
    check("up_9999_wrap", 16'(wrap_a), 16'h0000);
    cyc(4);
    check("up_wrap_cnt", cnt_a, 16'h0000);
    check("up_wrap", 16'(wrap_a), 16'h0001);

    // down wrap and invalid-digit load
    up_down = 1'b0;
    do_load(16'h0001);
    cyc(8);
    check("down_wrap_cnt", cnt_a, 16'h9999);
    check("down_wrap", 16'(wrap_a), 16'h0001);
    do_load(16'h00A5);
    check("load_sanitize", cnt_a, 16'h0005);

    // clear and load together while a step is due
    up_down = 1'b1;
    cyc(3);
    clear = 1'b1; load = 1'b1; load_value = 16'h1234;
    cyc();
    clear = 1'b0; load = 1'b0;
    check("clr_load_cnt", cnt_a, 16'h0000);
    check("clr_load_tick", 16'(tick_a), 16'h0000);
    cyc(3);
    check("clr_no_tick", 16'(tick_a), 16'h0000);
    cyc();
    check("clr_next_tick", 16'(tick_a), 16'h0001);

    // blanking / inverted polarity
    enable = 1'b0;
    do_load(16'h0070);
    cyc();
    check("blank_seg3", 16'(b3), 16'(7'b1111111));
    check("blank_seg2", 16'(b2), 16'(7'b1111111));
    check("blank_seg1", 16'(b1), 16'(7'b0001111));
    check("blank_seg0", 16'(b0), 16'(7'b0000001));

    // enable freeze and async reset
    enable = 1'b1;
    cyc(2);
    enable = 1'b0;
    cyc(10);
    check("freeze_cnt", cnt_a, 16'h0070);
    enable = 1'b1;
    cyc();
    check("resume_no_tick", 16'(tick_a), 16'h0000);
    cyc();
    check("resume_tick", 16'(tick_a), 16'h0001);
    check("resume_cnt", cnt_a, 16'h0071);
    #2 reset = 1'b1;
    #1;
    check("async_rst_cnt", cnt_a, 16'h0000);
    check("async_rst_tick", 16'(tick_a), 16'h0000);
    cyc();
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up_down = ~up_down;
      clear   = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 4))
        0:       load_value = 16'h9997;
        1:       load_value = 16'h0002;
        2:       load_value = 16'(load_to_int(16'($urandom_range(0, 65535))));
        default: load_value = 16'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        cyc();
        reset = 1'b0;
      end else begin
        cyc();
      end
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
